fp_add_pipe: RTL and testbench

Parametrised, three-stage pipelined floating-point adder/subtractor for the CPU datapath's 12-bit register-file format (default: sign, 4-bit exponent, 7-bit mantissa). It accepts one operation per cycle. It handles operand ordering, signs, subtraction, full normalisation, and overflow/underflow flags, which the single-cycle unsigned adder did not. It sits between the register-file read ports and the write-back mux, qualified by a valid strobe.

---
 rtl/fp_add_if.sv | 27 ++
 rtl/fp_add_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_fp_add_pipe.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fp_add_if.sv
// Operation/result bundle between the register-file read ports, the FP adder
// and the write-back mux.
interface fp_add_if #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 7
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic [W-1:0] result;
    logic         ovf;
    logic         unf;

    modport master (
        output in_valid, op, a, b,
        input  out_valid, result, ovf, unf
    );

    modport slave (
        input  in_valid, op, a, b,
        output out_valid, result, ovf, unf
    );
endinterface

// File: rtl/fp_add_pipe.sv
// Pipelined floating-point adder/subtractor for the 12-bit register-file format:
// operand capture/order, align/add, normalise/pack, then a holding output register.
module fp_add_pipe #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 7,
    parameter int BIAS  = 7
) (
    input  logic    clk,
    input  logic    rst,
    fp_add_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int M  = MAN_W + 1;
    localparam int SW = MAN_W + 2;
    localparam int XW = EXP_W + 2;
    localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    // The bias only offsets the stored exponent; add/normalise never need it.
    logic [EXP_W-1:0] bias_unused_s;
    assign bias_unused_s = EXP_W'(BIAS);

    function automatic logic [XW-1:0] lead_zeros(input logic [M-1:0] v);
        logic [XW-1:0] n;
        logic          found;
        n     = '0;
        found = 1'b0;
        for (int i = M - 1; i >= 0; i--) begin
            if (!found && !v[i]) begin
                n = n + XW'(1);
            end else begin
                found = 1'b1;
            end
        end
        return n;
    endfunction

    logic         s1_valid_r;
    logic         s1_op_r;
    logic [W-1:0] s1_a_r;
    logic [W-1:0] s1_b_r;

    // Operand capture register (S1 input)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= 1'b0;
            s1_a_r     <= '0;
            s1_b_r     <= '0;
        end else begin
            s1_valid_r <= bus.in_valid;
            s1_op_r    <= bus.op;
            s1_a_r     <= bus.a;
            s1_b_r     <= bus.b;
        end
    end

    logic             a_sign_s, b_sign_s, x_sign_s, y_sign_s, swap_s, eff_sub_s;
    logic [EXP_W-1:0] a_e_s, b_e_s, x_e_s, y_e_s, k_s;
    logic [MAN_W-1:0] a_m_s, b_m_s;
    logic [M-1:0]     x_m_s, y_m_s;

    // S1: unpack, fold op into b's sign, order by magnitude (ties keep a as X)
    always_comb begin
        a_sign_s = s1_a_r[W-1];
        b_sign_s = s1_b_r[W-1] ^ s1_op_r;
        a_e_s    = s1_a_r[W-2:MAN_W];
        b_e_s    = s1_b_r[W-2:MAN_W];
        a_m_s    = (a_e_s != '0) ? s1_a_r[MAN_W-1:0] : '0;
        b_m_s    = (b_e_s != '0) ? s1_b_r[MAN_W-1:0] : '0;
        swap_s   = ({b_e_s, b_m_s} > {a_e_s, a_m_s});
        // A zero operand also loses its hidden one so it contributes nothing.
        if (swap_s) begin
            x_sign_s = b_sign_s;
            x_e_s    = b_e_s;
            x_m_s    = {(b_e_s != '0), b_m_s};
            y_sign_s = a_sign_s;
            y_e_s    = a_e_s;
            y_m_s    = {(a_e_s != '0), a_m_s};
        end else begin
            x_sign_s = a_sign_s;
            x_e_s    = a_e_s;
            x_m_s    = {(a_e_s != '0), a_m_s};
            y_sign_s = b_sign_s;
            y_e_s    = b_e_s;
            y_m_s    = {(b_e_s != '0), b_m_s};
        end
        k_s       = x_e_s - y_e_s;
        eff_sub_s = x_sign_s ^ y_sign_s;
    end

    logic             s2_valid_r, s2_sign_r, s2_eff_sub_r;
    logic [EXP_W-1:0] s2_x_e_r, s2_k_r;
    logic [M-1:0]     s2_x_m_r, s2_y_m_r;

    // S1 -> S2 pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r   <= 1'b0;
            s2_sign_r    <= 1'b0;
            s2_eff_sub_r <= 1'b0;
            s2_x_e_r     <= '0;
            s2_k_r       <= '0;
            s2_x_m_r     <= '0;
            s2_y_m_r     <= '0;
        end else begin
            s2_valid_r   <= s1_valid_r;
            s2_sign_r    <= x_sign_s;
            s2_eff_sub_r <= eff_sub_s;
            s2_x_e_r     <= x_e_s;
            s2_k_r       <= k_s;
            s2_x_m_r     <= x_m_s;
            s2_y_m_r     <= y_m_s;
        end
    end

    logic [M-1:0]  y_sh_s;
    logic [SW-1:0] sum_s;

    // S2: truncating alignment of the smaller operand, then add or subtract
    always_comb begin
        if (32'(s2_k_r) >= 32'(M)) begin
            y_sh_s = '0;
        end else begin
            y_sh_s = s2_y_m_r >> s2_k_r;
        end
        if (s2_eff_sub_r) begin
            sum_s = {1'b0, s2_x_m_r} - {1'b0, y_sh_s};
        end else begin
            sum_s = {1'b0, s2_x_m_r} + {1'b0, y_sh_s};
        end
    end

    logic             s3_valid_r, s3_sign_r;
    logic [EXP_W-1:0] s3_x_e_r;
    logic [SW-1:0]    s3_sum_r;

    // S2 -> S3 pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid_r <= 1'b0;
            s3_sign_r  <= 1'b0;
            s3_x_e_r   <= '0;
            s3_sum_r   <= '0;
        end else begin
            s3_valid_r <= s2_valid_r;
            s3_sign_r  <= s2_sign_r;
            s3_x_e_r   <= s2_x_e_r;
            s3_sum_r   <= sum_s;
        end
    end

    logic [XW-1:0]    lz_s;
    logic [XW-1:0]    exp_s;
    logic [MAN_W-1:0] man_s;
    logic [W-1:0]     res_s;
    logic             ovf_s, unf_s;

    // S3: normalise; exp_s is two's complement so underflow shows as its top bit
    always_comb begin
        lz_s = lead_zeros(s3_sum_r[M-1:0]);
        if (s3_sum_r[SW-1]) begin
            man_s = s3_sum_r[MAN_W:1];
            exp_s = {2'b00, s3_x_e_r} + XW'(1);
        end else begin
            man_s = MAN_W'(s3_sum_r[M-1:0] << lz_s);
            exp_s = {2'b00, s3_x_e_r} - lz_s;
        end
        if (s3_sum_r == '0) begin
            res_s = '0;
            ovf_s = 1'b0;
            unf_s = 1'b0;
        end else if (!exp_s[XW-1] && (exp_s > EXP_MAX)) begin
            res_s = {s3_sign_r, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
            ovf_s = 1'b1;
            unf_s = 1'b0;
        end else if (exp_s[XW-1] || (exp_s == '0)) begin
            res_s = '0;
            ovf_s = 1'b0;
            unf_s = 1'b1;
        end else begin
            res_s = {s3_sign_r, exp_s[EXP_W-1:0], man_s};
            ovf_s = 1'b0;
            unf_s = 1'b0;
        end
    end

    logic         out_valid_r, ovf_r, unf_r;
    logic [W-1:0] result_r;

    // Output register: loads only on a valid S3, otherwise holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            result_r    <= '0;
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
        end else begin
            out_valid_r <= s3_valid_r;
            if (s3_valid_r) begin
                result_r <= res_s;
                ovf_r    <= ovf_s;
                unf_r    <= unf_s;
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.ovf       = ovf_r;
    assign bus.unf       = unf_r;
endmodule

// File: tb/tb_fp_add_pipe.sv
// Self-checking bench for fp_add_pipe: vector table streamed through a scoreboard
// (value + arrival cycle), output-hold checks, and an asynchronous mid-stream reset.
module tb_fp_add_pipe;
    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic        op;
        logic [11:0] res;
        logic        ovf;
        logic        unf;
        int          gap;
    } vec_t;

    typedef struct {
        logic [11:0] res;
        logic        ovf;
        logic        unf;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic [11:0] held_res = 12'h000;
    logic        held_ovf = 1'b0;
    logic        held_unf = 1'b0;
    vec_t vecs[17];

    fp_add_if #(.EXP_W(4), .MAN_W(7)) bus ();

    fp_add_pipe #(.EXP_W(4), .MAN_W(7), .BIAS(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        bus.in_valid = 1'b1;
        bus.a        = v.a;
        bus.b        = v.b;
        bus.op       = v.op;
        e.res = v.res;
        e.ovf = v.ovf;
        e.unf = v.unf;
        e.due = cyc + 4;
        sb_q.push_back(e);
    endtask

    initial begin : cycle_counter
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.out_valid) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("result", 32'(bus.result), 32'(mon_e.res));
                        check("ovf", 32'(bus.ovf), 32'(mon_e.ovf));
                        check("unf", 32'(bus.unf), 32'(mon_e.unf));
                        check("arrival_cycle", 32'(cyc), 32'(mon_e.due));
                        held_res = mon_e.res;
                        held_ovf = mon_e.ovf;
                        held_unf = mon_e.unf;
                    end
                end else begin
                    check("hold_result", 32'(bus.result), 32'(held_res));
                    check("hold_ovf", 32'(bus.ovf), 32'(held_ovf));
                    check("hold_unf", 32'(bus.unf), 32'(held_unf));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        //            a        b        op    result   ovf   unf   gap
        vecs[0]  = '{12'h380, 12'h380, 1'b0, 12'h400, 1'b0, 1'b0, 0};
        vecs[1]  = '{12'h3C0, 12'h3C0, 1'b0, 12'h440, 1'b0, 1'b0, 0};
        vecs[2]  = '{12'h380, 12'h440, 1'b0, 12'h480, 1'b0, 1'b0, 0};
        vecs[3]  = '{12'h380, 12'hBC0, 1'b0, 12'hB00, 1'b0, 1'b0, 2};
        vecs[4]  = '{12'h440, 12'h380, 1'b1, 12'h400, 1'b0, 1'b0, 0};
        vecs[5]  = '{12'h700, 12'h380, 1'b0, 12'h701, 1'b0, 1'b0, 3};
        vecs[6]  = '{12'h780, 12'h380, 1'b0, 12'h780, 1'b0, 1'b0, 0};
        vecs[7]  = '{12'h000, 12'h3C0, 1'b1, 12'hBC0, 1'b0, 1'b0, 1};
        vecs[8]  = '{12'h380, 12'h380, 1'b1, 12'h000, 1'b0, 1'b0, 0};
        vecs[9]  = '{12'h7FF, 12'h7FF, 1'b0, 12'h7FF, 1'b1, 1'b0, 0};
        vecs[10] = '{12'h0C0, 12'h080, 1'b1, 12'h000, 1'b0, 1'b1, 1};
        vecs[11] = '{12'h000, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 0};
        vecs[12] = '{12'hFFF, 12'hFFF, 1'b0, 12'hFFF, 1'b1, 1'b0, 0};
        vecs[13] = '{12'hBC0, 12'h3C0, 1'b0, 12'h000, 1'b0, 1'b0, 2};
        vecs[14] = '{12'h380, 12'h000, 1'b1, 12'h380, 1'b0, 1'b0, 0};
        vecs[15] = '{12'h3C0, 12'hB80, 1'b1, 12'h420, 1'b0, 1'b0, 0};
        vecs[16] = '{12'h400, 12'h381, 1'b0, 12'h440, 1'b0, 1'b0, 0};

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.op       = 1'b0;
        bus.a        = 12'h000;
        bus.b        = 12'h000;
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_result", 32'(bus.result), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Streaming table with gaps; the scoreboard checks value and arrival cycle
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            if (vecs[i].gap > 0) begin
                bus.in_valid = 1'b0;
                repeat (vecs[i].gap) @(negedge clk);
            end
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_table", 32'(sb_q.size()), 32'd0);
        repeat (3) @(negedge clk);

        // Asynchronous reset with three operations in flight
        drive(vecs[0]);
        @(negedge clk);
        drive(vecs[9]);
        @(negedge clk);
        drive(vecs[2]);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        check("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
        check("pre_reset_result", 32'(bus.result), 32'h400);
        sb_q.delete();
        held_res = 12'h000;
        held_ovf = 1'b0;
        held_unf = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_result", 32'(bus.result), 32'd0);
        check("async_rst_ovf", 32'(bus.ovf), 32'd0);
        check("async_rst_unf", 32'(bus.unf), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("post_reset_queue", 32'(sb_q.size()), 32'd0);

        // One fresh operation after reset still flows normally
        drive(vecs[15]);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_post_reset", 32'(sb_q.size()), 32'd0);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
